// File: rtl/gcd_operand_fifo_if.sv
// Handshake bundle between an operand producer, the operand FIFO and the gcd unit.
// The slave modport is the FIFO's view; master is the producer/consumer side.
interface gcd_operand_fifo_if #(
   parameter int W     = 16,
   parameter int DEPTH = 4
);
   logic [W-1:0]               enq_bits_A;
   logic [W-1:0]               enq_bits_B;
   logic                       enq_val;
   logic                       enq_rdy;
   logic [W-1:0]               deq_bits_A;
   logic [W-1:0]               deq_bits_B;
   logic                       deq_val;
   logic                       deq_rdy;
   logic [$clog2(DEPTH+1)-1:0] count;

   modport slave (
      input  enq_bits_A, enq_bits_B, enq_val, deq_rdy,
      output enq_rdy, deq_bits_A, deq_bits_B, deq_val, count
   );

   modport master (
      output enq_bits_A, enq_bits_B, enq_val, deq_rdy,
      input  enq_rdy, deq_bits_A, deq_bits_B, deq_val, count
   );
endinterface

// File: rtl/gcd_operand_fifo.sv
// Operand-pair FIFO in front of the gcd unit; ready/valid outputs decode registered
// occupancy only, so no combinational path runs from deq_rdy to enq_rdy.
module gcd_operand_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   gcd_operand_fifo_if.slave      io
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } pair_t;

   pair_t         mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic          enq_fire, deq_fire;

   assign io.enq_rdy    = (cnt != CW'(DEPTH));
   assign io.deq_val    = (cnt != '0);
   assign io.count      = cnt;
   assign io.deq_bits_A = mem[rp].a;
   assign io.deq_bits_B = mem[rp].b;

   assign enq_fire = io.enq_val && io.enq_rdy;
   assign deq_fire = io.deq_val && io.deq_rdy;

   // Storage carries no reset; stale entries are never visible because deq_val gates them.
   always_ff @(posedge clk) begin
      if (enq_fire) mem[wp] <= '{a: io.enq_bits_A, b: io.enq_bits_B};
   end

   // DEPTH is a power of two, so pointer wrap is plain binary overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (enq_fire) wp <= wp + AW'(1);
         if (deq_fire) rp <= rp + AW'(1);
         if (enq_fire && !deq_fire)      cnt <= cnt + CW'(1);
         else if (deq_fire && !enq_fire) cnt <= cnt - CW'(1);
      end
   end
endmodule
